// File: rtl/branch_unit.sv
// branch_unit: program sequencer with flag-conditioned LUT branches, post-branch flush bubbles and halt.
module branch_unit #(
  parameter int IW = 9,
  parameter int OPW = 4,
  parameter int PCW = 10,
  parameter int FLUSH = 1,
  parameter logic [OPW-1:0] BRC_OP = 4'b1101,
  parameter logic [OPW-1:0] HALT_OP = 4'b1111,
  localparam int TW = IW - OPW - 2
) (
  input  logic           Clk,
  input  logic           Reset,
  input  logic           start,
  input  logic [IW-1:0]  instr,
  input  logic           alu_zero,
  input  logic           alu_carry,
  input  logic           flag_we,
  input  logic           lut_we,
  input  logic [TW-1:0]  lut_addr,
  input  logic [PCW-1:0] lut_data,
  output logic [PCW-1:0] pc,
  output logic           instr_valid,
  output logic           branch_taken,
  output logic           halted
);
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FLUSH, S_HALT} state_t;
  localparam logic [3:0] FLUSH_CNT = FLUSH > 0 ? 4'(FLUSH - 1) : 4'd0;
  state_t state_q, state_d;
  logic [PCW-1:0] pc_q, pc_d;
  logic [3:0] cnt_q, cnt_d;
  logic z_q, z_d, c_q, c_d;
  logic [PCW-1:0] lut_q [2**TW];
  logic [OPW-1:0] opcode;
  logic [1:0] cond;
  logic [TW-1:0] idx;
  logic cond_ok;
  assign opcode = instr[IW-1:IW-OPW];
  assign cond = instr[TW+1:TW];
  assign idx = instr[TW-1:0];
  // branches see flags and LUT as they were before this edge
  assign cond_ok = cond == 2'd0 ? 1'b1 : cond == 2'd1 ? z_q : cond == 2'd2 ? !z_q : c_q;
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= S_IDLE;
      pc_q <= '0;
      cnt_q <= '0;
      z_q <= 1'b0;
      c_q <= 1'b0;
      for (int i = 0; i < 2**TW; i++) lut_q[i] <= '0;
    end else begin
      state_q <= state_d;
      pc_q <= pc_d;
      cnt_q <= cnt_d;
      z_q <= z_d;
      c_q <= c_d;
      if (lut_we) lut_q[lut_addr] <= lut_data;
    end
  end
  always_comb begin
    state_d = state_q;
    pc_d = pc_q;
    cnt_d = cnt_q;
    z_d = flag_we ? alu_zero : z_q;
    c_d = flag_we ? alu_carry : c_q;
    case (state_q)
      S_IDLE, S_HALT: begin
        state_d = start ? S_RUN : state_q;
        pc_d = start ? '0 : pc_q;
      end
      S_RUN: begin
        if (opcode == HALT_OP) begin
          state_d = S_HALT;
        end else if (branch_taken) begin
          pc_d = lut_q[idx];
          state_d = FLUSH > 0 ? S_FLUSH : S_RUN;
          cnt_d = FLUSH_CNT;
        end else begin
          pc_d = pc_q + PCW'(1);
        end
      end
      default: begin
        state_d = cnt_q == 4'd0 ? S_RUN : S_FLUSH;
        cnt_d = cnt_q == 4'd0 ? 4'd0 : cnt_q - 4'd1;
      end
    endcase
  end
  always_comb begin
    pc = pc_q;
    instr_valid = state_q == S_RUN;
    halted = state_q == S_HALT;
    branch_taken = instr_valid && opcode == BRC_OP && cond_ok;
  end
endmodule

// File: tb/tb_branch_unit.sv
// tb_branch_unit: vector table, corner sequences and random run against a behavioural model for FLUSH=1 and FLUSH=3.
module tb_branch_unit;
  localparam int IW = 9, PCW = 10, TW = 3;
  logic Clk = 1'b0;
  logic Reset, start, alu_zero, alu_carry, flag_we, lut_we;
  logic [IW-1:0] instr;
  logic [TW-1:0] lut_addr;
  logic [PCW-1:0] lut_data;
  logic [PCW-1:0] pc1, pc3;
  logic v1, v3, t1, t3, h1, h3;
  always #5 Clk = ~Clk;

  branch_unit #(.FLUSH(1)) d1 (.Clk(Clk), .Reset(Reset), .start(start), .instr(instr),
    .alu_zero(alu_zero), .alu_carry(alu_carry), .flag_we(flag_we), .lut_we(lut_we),
    .lut_addr(lut_addr), .lut_data(lut_data), .pc(pc1), .instr_valid(v1),
    .branch_taken(t1), .halted(h1));
  branch_unit #(.FLUSH(3)) d3 (.Clk(Clk), .Reset(Reset), .start(start), .instr(instr),
    .alu_zero(alu_zero), .alu_carry(alu_carry), .flag_we(flag_we), .lut_we(lut_we),
    .lut_addr(lut_addr), .lut_data(lut_data), .pc(pc3), .instr_valid(v3),
    .branch_taken(t3), .halted(h3));

  int checks = 0, errors = 0;
  // model: mode 0 idle, 1 run, 2 bubble, 3 halt; bub = bubbles still to go
  int mpc[2], mode[2], bub[2], mlut[2][8];
  bit mz[2], mc[2];

  typedef struct {
    logic rst, st;
    logic [8:0] ins;
    logic fwe, az, ac, lwe;
    logic [2:0] la;
    logic [9:0] ld;
    logic [9:0] epc;
    logic ev, et, eh;
  } vec_t;
  vec_t tbl[32];

  function automatic logic [8:0] mk(input int op, input int cnd, input int ix);
    return {4'(op), 2'(cnd), 3'(ix)};
  endfunction

  function automatic vec_t v(input logic rst, st, input logic [8:0] ins, input logic fwe, az,
                             input logic lwe, input logic [2:0] la, input logic [9:0] ld,
                             input logic [9:0] epc, input logic ev, et, eh);
    vec_t r;
    r = '{rst, st, ins, fwe, az, 1'b0, lwe, la, ld, epc, ev, et, eh};
    return r;
  endfunction

  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", n, a, e, $time);
    end
  endtask

  function automatic bit m_taken(input int k);
    int op, cnd;
    op = int'(instr[8:5]);
    cnd = int'(instr[4:3]);
    return mode[k] == 1 && op == 13 &&
      (cnd == 0 || (cnd == 1 && mz[k]) || (cnd == 2 && !mz[k]) || (cnd == 3 && mc[k]));
  endfunction

  task automatic m_check();
    chk("m_pc1", 32'(pc1), 32'(mpc[0]));
    chk("m_valid1", 32'(v1), 32'(mode[0] == 1));
    chk("m_taken1", 32'(t1), 32'(m_taken(0)));
    chk("m_halt1", 32'(h1), 32'(mode[0] == 3));
    chk("m_pc3", 32'(pc3), 32'(mpc[1]));
    chk("m_valid3", 32'(v3), 32'(mode[1] == 1));
    chk("m_taken3", 32'(t3), 32'(m_taken(1)));
    chk("m_halt3", 32'(h3), 32'(mode[1] == 3));
  endtask

  task automatic m_update();
    for (int k = 0; k < 2; k++) begin
      int fl;
      bit tk;
      fl = k ? 3 : 1;
      tk = m_taken(k);
      if (Reset) begin
        mpc[k] = 0; mode[k] = 0; bub[k] = 0; mz[k] = 0; mc[k] = 0;
        for (int j = 0; j < 8; j++) mlut[k][j] = 0;
      end else begin
        if (mode[k] == 0 || mode[k] == 3) begin
          if (start) begin mode[k] = 1; mpc[k] = 0; end
        end else if (mode[k] == 1) begin
          if (instr[8:5] == 4'hF) mode[k] = 3;
          else if (tk) begin
            mpc[k] = mlut[k][lut_addr === lut_addr ? int'(instr[2:0]) : 0];
            if (fl > 0) begin mode[k] = 2; bub[k] = fl; end
          end else mpc[k] = (mpc[k] + 1) % 1024;
        end else begin
          bub[k]--;
          if (bub[k] == 0) mode[k] = 1;
        end
        if (lut_we) mlut[k][int'(lut_addr)] = int'(lut_data);
        if (flag_we) begin mz[k] = alu_zero; mc[k] = alu_carry; end
      end
    end
  endtask

  task automatic step();
    #1;
    m_check();
    @(posedge Clk);
    m_update();
    @(negedge Clk);
  endtask

  task automatic set_in(input logic rst, st, input logic [8:0] ins, input logic fwe, az, ac,
                        input logic lwe, input logic [2:0] la, input logic [9:0] ld);
    Reset = rst; start = st; instr = ins; flag_we = fwe; alu_zero = az; alu_carry = ac;
    lut_we = lwe; lut_addr = la; lut_data = ld;
  endtask

  localparam logic [8:0] NOP = 9'h000;

  initial begin
    set_in(1, 0, NOP, 0, 0, 0, 0, 0, 0);
    @(posedge Clk);
    m_update();
    @(negedge Clk);
    tbl[0]  = v(0, 0, NOP,          0, 0, 0, 0, 10'h000, 10'h000, 0, 0, 0);
    tbl[1]  = v(0, 1, NOP,          0, 0, 1, 5, 10'h040, 10'h000, 0, 0, 0);
    tbl[2]  = v(0, 0, NOP,          0, 0, 0, 0, 10'h000, 10'h000, 1, 0, 0);
    tbl[3]  = v(0, 0, NOP,          0, 0, 0, 0, 10'h000, 10'h001, 1, 0, 0);
    tbl[4]  = v(0, 0, NOP,          0, 0, 0, 0, 10'h000, 10'h002, 1, 0, 0);
    tbl[5]  = v(0, 0, NOP,          1, 1, 0, 0, 10'h000, 10'h003, 1, 0, 0);
    tbl[6]  = v(0, 0, mk(13, 1, 5), 0, 0, 0, 0, 10'h000, 10'h004, 1, 1, 0);
    tbl[7]  = v(0, 0, NOP,          0, 0, 0, 0, 10'h000, 10'h040, 0, 0, 0);
    tbl[8]  = v(0, 0, NOP,          1, 0, 0, 0, 10'h000, 10'h040, 1, 0, 0);
    tbl[9]  = v(0, 0, mk(13, 1, 5), 1, 1, 0, 0, 10'h000, 10'h041, 1, 0, 0);
    tbl[10] = v(0, 0, NOP,          0, 0, 0, 0, 10'h000, 10'h042, 1, 0, 0);
    tbl[11] = v(0, 0, mk(13, 3, 5), 0, 0, 0, 0, 10'h000, 10'h043, 1, 0, 0);
    tbl[12] = v(0, 0, mk(13, 0, 2), 0, 0, 1, 2, 10'h100, 10'h044, 1, 1, 0);
    tbl[13] = v(0, 0, NOP,          0, 0, 0, 0, 10'h000, 10'h000, 0, 0, 0);
    tbl[14] = v(0, 0, mk(13, 0, 2), 0, 0, 0, 0, 10'h000, 10'h000, 1, 1, 0);
    tbl[15] = v(0, 0, NOP,          0, 0, 0, 0, 10'h000, 10'h100, 0, 0, 0);
    tbl[16] = v(0, 0, mk(15, 0, 0), 0, 0, 0, 0, 10'h000, 10'h100, 1, 0, 0);
    tbl[17] = v(0, 0, NOP,          0, 0, 0, 0, 10'h000, 10'h100, 0, 0, 1);
    tbl[18] = v(0, 1, NOP,          0, 0, 0, 0, 10'h000, 10'h100, 0, 0, 1);
    tbl[19] = v(0, 0, NOP,          0, 0, 1, 7, 10'h3FF, 10'h000, 1, 0, 0);
    tbl[20] = v(0, 0, mk(13, 0, 7), 0, 0, 0, 0, 10'h000, 10'h001, 1, 1, 0);
    tbl[21] = v(0, 0, NOP,          0, 0, 0, 0, 10'h000, 10'h3FF, 0, 0, 0);
    tbl[22] = v(0, 0, NOP,          0, 0, 0, 0, 10'h000, 10'h3FF, 1, 0, 0);
    tbl[23] = v(0, 0, NOP,          0, 0, 0, 0, 10'h000, 10'h000, 1, 0, 0);
    tbl[24] = v(0, 0, NOP,          0, 0, 0, 0, 10'h000, 10'h001, 1, 0, 0);
    tbl[25] = v(0, 0, mk(15, 0, 0), 0, 0, 0, 0, 10'h000, 10'h002, 1, 0, 0);
    tbl[26] = v(0, 0, NOP,          0, 0, 0, 0, 10'h000, 10'h002, 0, 0, 1);
    tbl[27] = v(0, 1, NOP,          0, 0, 0, 0, 10'h000, 10'h002, 0, 0, 1);
    tbl[28] = v(0, 1, NOP,          0, 0, 0, 0, 10'h000, 10'h000, 1, 0, 0);
    tbl[29] = v(0, 0, NOP,          0, 0, 0, 0, 10'h000, 10'h001, 1, 0, 0);
    tbl[30] = v(1, 1, NOP,          1, 1, 1, 3, 10'h155, 10'h002, 1, 0, 0);
    tbl[31] = v(0, 0, NOP,          0, 0, 0, 0, 10'h000, 10'h000, 0, 0, 0);
    for (int i = 0; i < 32; i++) begin
      set_in(tbl[i].rst, tbl[i].st, tbl[i].ins, tbl[i].fwe, tbl[i].az, tbl[i].ac,
             tbl[i].lwe, tbl[i].la, tbl[i].ld);
      #1;
      chk($sformatf("vec%0d_pc", i), 32'(pc1), 32'(tbl[i].epc));
      chk($sformatf("vec%0d_valid", i), 32'(v1), 32'(tbl[i].ev));
      chk($sformatf("vec%0d_taken", i), 32'(t1), 32'(tbl[i].et));
      chk($sformatf("vec%0d_halted", i), 32'(h1), 32'(tbl[i].eh));
      step();
    end
    // reset in the middle of a three-bubble flush
    set_in(0, 1, NOP, 0, 0, 0, 1, 5, 10'h040); step();
    set_in(0, 0, NOP, 0, 0, 0, 0, 0, 0); step();
    set_in(0, 0, mk(13, 0, 5), 0, 0, 0, 0, 0, 0); #1; chk("f3_taken", 32'(t3), 1); step();
    set_in(0, 0, NOP, 0, 0, 0, 0, 0, 0); #1;
    chk("f3_bub1_pc", 32'(pc3), 32'h040); chk("f3_bub1_valid", 32'(v3), 0); step();
    set_in(1, 1, NOP, 1, 1, 1, 1, 5, 10'h2AA); #1; chk("f3_bub2_valid", 32'(v3), 0); step();
    set_in(0, 0, NOP, 0, 0, 0, 0, 0, 0); #1;
    chk("f3_rst_pc", 32'(pc3), 0); chk("f3_rst_valid", 32'(v3), 0); chk("f3_rst_halt", 32'(h3), 0);
    step();
    set_in(0, 1, NOP, 0, 0, 0, 0, 0, 0); step();
    set_in(0, 0, mk(13, 0, 5), 0, 0, 0, 0, 0, 0); #1;
    chk("f3_run_pc", 32'(pc3), 0); chk("f3_run_taken", 32'(t3), 1); step();
    set_in(0, 0, NOP, 0, 0, 0, 0, 0, 0); #1;
    chk("f3_lut_cleared_pc", 32'(pc3), 0); chk("f3_after_valid", 32'(v3), 0); step();
    for (int i = 0; i < 3000; i++) begin
      logic [8:0] ins;
      ins = 9'($urandom);
      if ($urandom_range(0, 2) == 0) ins[8:5] = 4'hD;
      set_in($urandom_range(0, 99) == 0, $urandom_range(0, 3) == 0, ins,
             $urandom_range(0, 2) == 0, 1'($urandom), 1'($urandom),
             $urandom_range(0, 3) == 0, 3'($urandom), 10'($urandom));
      step();
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/branch_unit.md
BRANCH_UNIT -- requirements
Module: branch_unit

Interface
REQ-001 Parameter IW, default 9, instruction width in bits.
REQ-002 Parameter OPW, default 4, opcode width; opcode = instr[IW-1:IW-OPW].
REQ-003 Parameter PCW, default 10, program counter width.
REQ-004 Parameter FLUSH, default 1, bubble cycles after a taken branch (0..15).
REQ-005 Parameter BRC_OP, default 4'b1101, branch opcode.
REQ-006 Parameter HALT_OP, default 4'b1111, halt opcode.
REQ-007 Derived TW = IW-OPW-2, target index width; cond = instr[TW+1:TW], idx = instr[TW-1:0].
REQ-008 Clk  input  1  single clock; all state updates on rising edge.
REQ-009 Reset  input  1  synchronous, active-high reset.
REQ-010 start  input  1  launch execution from pc 0.
REQ-011 instr  input  IW  instruction fetched at the current pc.
REQ-012 alu_zero  input  1  ALU result equals zero.
REQ-013 alu_carry  input  1  ALU carry out.
REQ-014 flag_we  input  1  latch alu_zero/alu_carry into the flag register.
REQ-015 lut_we  input  1  write the branch target LUT.
REQ-016 lut_addr  input  TW  LUT write index.
REQ-017 lut_data  input  PCW  LUT write data.
REQ-018 pc  output  PCW  current fetch address.
REQ-019 instr_valid  output  1  instr is being executed this cycle.
REQ-020 branch_taken  output  1  one-cycle pulse in the cycle a taken branch executes.
REQ-021 halted  output  1  unit is in HALT.

Function
REQ-022 The unit SHALL implement states IDLE, RUN, FLUSH, HALT; instr_valid = 1 only in RUN, halted = 1 only in HALT.
REQ-023 In IDLE or HALT, start=1 SHALL set pc <= 0 and state <= RUN; start SHALL be ignored in RUN and FLUSH.
REQ-024 Flags SHALL be registered: flag_we=1 loads Z <= alu_zero and C <= alu_carry in any state; flags hold otherwise.
REQ-025 Branch condition SHALL be cond 00 always, 01 Z=1, 10 Z=0, 11 C=1, evaluated on registered flags; flag_we in the same cycle as a branch SHALL NOT affect that branch.
REQ-026 LUT SHALL hold 2^TW entries of PCW bits; lut_we writes at the clock edge; a branch reading the address being written in the same cycle SHALL use the old entry.
REQ-027 In RUN with opcode = BRC_OP and condition true: pc <= LUT[idx], branch_taken = 1 (combinational, that cycle), state <= FLUSH if FLUSH>0 else RUN.
REQ-028 In RUN with opcode = BRC_OP and condition false: pc <= pc+1, branch_taken = 0.
REQ-029 In RUN with opcode = HALT_OP: pc holds, state <= HALT.
REQ-030 In RUN with any other opcode: pc <= pc+1.
REQ-031 pc+1 SHALL wrap modulo 2^PCW (all-ones -> 0) with no flag or error.
REQ-032 In FLUSH a down-counter loaded with FLUSH-1 on entry SHALL count one per cycle; pc holds; state <= RUN when counter = 0, giving exactly FLUSH bubble cycles.
REQ-033 instr SHALL be ignored whenever instr_valid = 0.
REQ-034 branch_taken SHALL be 0 in every state other than RUN.

Reset
REQ-035 Reset=1 SHALL, at the next edge, force state IDLE, pc 0, Z 0, C 0, flush counter 0, all LUT entries 0, from any state including mid-FLUSH.
REQ-036 Reset SHALL take priority over start, flag_we and lut_we in the same cycle.
REQ-037 While in IDLE after reset: pc = 0, instr_valid = 0, branch_taken = 0, halted = 0.

Verification
REQ-038 Reset, start, feed 3 non-branch instrs -> pc 0,1,2,3; instr_valid = 1 each cycle.
REQ-039 LUT[5]=0x040, flag_we with alu_zero=1, then branch cond 01 idx 5 -> branch_taken pulse, pc = 0x040, instr_valid = 0 for exactly FLUSH (1) cycle.
REQ-040 Z=0, branch cond 01 at pc 7 -> not taken, pc = 8, no bubble; same-cycle flag_we with alu_zero=1 does not make it taken.
REQ-041 pc = 0x3FF, non-branch instr -> pc = 0x000; HALT_OP at pc 2 -> halted = 1, pc stays 2; start -> pc 0, RUN.
REQ-042 FLUSH=3 build, taken branch, Reset asserted in 2nd bubble cycle -> IDLE, pc 0, LUT cleared, subsequent start runs from 0.
REQ-043 lut_we to idx 2 in same cycle as branch idx 2 (cond 00) -> pc takes old LUT[2]; next branch idx 2 takes new value.
